// File: rtl/gnn_0_example_bias_add_if.sv
// gnn_0_example_bias_add_if: control, bias-buffer read port and AXI4-Stream in/out of the bias adder
interface gnn_0_example_bias_add_if #(
  parameter int BIAS_ADD_INST_LENGTH = 96,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int LP_BUF_ADDR_WIDTH = 9
);
  logic ap_start;
  logic ap_done;
  logic [BIAS_ADD_INST_LENGTH-1:0] ctrl_instruction;
  logic [LP_BUF_ADDR_WIDTH-1:0] bias_read_buffer_a_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] bias_read_buffer_a_data;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata;
  logic m_axis_tlast;
  modport slave (
    input ap_start, ctrl_instruction, bias_read_buffer_a_data, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output ap_done, bias_read_buffer_a_addr, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
  modport master (
    output ap_start, ctrl_instruction, bias_read_buffer_a_data, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input ap_done, bias_read_buffer_a_addr, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/gnn_0_example_bias_add.sv
// gnn_0_example_bias_add: lane-wise bias add with optional ReLU on a 512-bit result stream
module gnn_0_example_bias_add #(
  parameter int BIAS_ADD_INST_LENGTH = 96,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH = 32,
  parameter int LP_BUF_ADDR_WIDTH = 9
) (
  input logic kernel_clk,
  input logic kernel_rst,
  gnn_0_example_bias_add_if.slave bus
);
  localparam int LANES = C_M_AXI_DATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = LP_BUF_ADDR_WIDTH;
  localparam int LW = C_ADDER_BIT_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] bias_start, next_addr, s1_addr;
  logic [15:0] bias_len, col, len_in;
  logic [31:0] total, in_cnt, out_cnt;
  logic relu_en, s1_valid, s1_last, m_valid, m_last, adv, accept;
  logic [DW-1:0] s1_data, m_data, res;
  logic unused_inst_bits;
  assign unused_inst_bits = ^{bus.ctrl_instruction[BIAS_ADD_INST_LENGTH-1:65], bus.ctrl_instruction[15:AW]};
  assign len_in = (bus.ctrl_instruction[31:16] == 16'd0) ? 16'd1 : bus.ctrl_instruction[31:16];
  assign next_addr = bias_start + col[AW-1:0];
  assign adv = s1_valid && (!m_valid || bus.m_axis_tready);
  assign bus.s_axis_tready = (state == RUN) && (in_cnt < total) && (!s1_valid || adv);
  assign accept = bus.s_axis_tvalid && bus.s_axis_tready;
  // Holding the address while S1 is stalled keeps the synchronous read data valid.
  assign bus.bias_read_buffer_a_addr = (s1_valid && !adv) ? s1_addr : next_addr;
  assign bus.ap_done = (state == DONE);
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tdata = m_data;
  assign bus.m_axis_tlast = m_last;
  always_comb begin
    state_nxt = (state == IDLE && bus.ap_start) ? RUN :
                (state == RUN && in_cnt == total && out_cnt == total) ? DONE :
                (state == DONE) ? IDLE : state;
  end
  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      res[k*LW +: LW] = s1_data[k*LW +: LW] + bus.bias_read_buffer_a_data[k*LW +: LW];
      if (relu_en && res[k*LW + LW - 1]) res[k*LW +: LW] = '0;
    end
  end
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state <= IDLE;
      bias_start <= '0;
      bias_len <= 16'd1;
      total <= '0;
      relu_en <= 1'b0;
      col <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_addr <= '0;
      s1_last <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.ap_start) begin
        bias_start <= bus.ctrl_instruction[AW-1:0];
        bias_len <= len_in;
        total <= bus.ctrl_instruction[63:32];
        relu_en <= bus.ctrl_instruction[64];
        col <= '0;
        in_cnt <= '0;
        out_cnt <= '0;
      end
      if (accept) begin
        col <= (col == bias_len - 16'd1) ? 16'd0 : col + 16'd1;
        in_cnt <= in_cnt + 32'd1;
        s1_valid <= 1'b1;
        s1_data <= bus.s_axis_tdata;
        s1_addr <= next_addr;
        s1_last <= (in_cnt == total - 32'd1);
      end else if (adv) s1_valid <= 1'b0;
      if (adv) begin
        m_valid <= 1'b1;
        m_data <= res;
        m_last <= s1_last;
      end else if (bus.m_axis_tready) m_valid <= 1'b0;
      if (m_valid && bus.m_axis_tready) out_cnt <= out_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_gnn_0_example_bias_add.sv
// tb_gnn_0_example_bias_add: directed stimulus with a queue scoreboard checked by an output monitor
module tb_gnn_0_example_bias_add;
  logic kernel_clk = 1'b0;
  logic kernel_rst = 1'b1;
  always #5 kernel_clk = ~kernel_clk;
  gnn_0_example_bias_add_if bif();
  gnn_0_example_bias_add dut (.kernel_clk(kernel_clk), .kernel_rst(kernel_rst), .bus(bif));
  typedef struct {logic [511:0] d; logic l;} exp_t;
  exp_t sb[$];
  logic [511:0] mem [512];
  logic [511:0] in_beats [16];
  logic [511:0] last_out;
  int checks = 0, errors = 0, done_cnt = 0, rdy_cnt = 0, nout = 0;
  int cur_bs, cur_len, cur_total, d0, rc;
  bit cur_relu, toggle = 0;
  always @(posedge kernel_clk) bif.bias_read_buffer_a_data <= mem[bif.bias_read_buffer_a_addr];
  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [511:0] ref_beat(logic [511:0] a, logic [511:0] b, bit relu);
    logic [31:0] s;
    ref_beat = '0;
    for (int k = 0; k < 16; k++) begin
      s = a[k*32 +: 32] + b[k*32 +: 32];
      ref_beat[k*32 +: 32] = (relu && s[31]) ? 32'd0 : s;
    end
  endfunction
  always @(negedge kernel_clk) begin
    if (bif.ap_done) done_cnt++;
    if (bif.s_axis_tready) rdy_cnt++;
    if (!kernel_rst && bif.m_axis_tvalid && bif.m_axis_tready) begin
      if (sb.size() == 0) chk("extra_beat", bif.m_axis_tdata, '0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", bif.m_axis_tdata, e.d);
        chk("beat_last", {511'd0, bif.m_axis_tlast}, {511'd0, e.l});
        last_out = bif.m_axis_tdata;
        nout++;
      end
    end
  end
  initial begin
    bif.m_axis_tready = 1'b1;
    forever begin
      @(posedge kernel_clk);
      #1 bif.m_axis_tready = toggle ? ~bif.m_axis_tready : 1'b1;
    end
  end
  task automatic start(int bs, int len, int total, bit relu);
    @(posedge kernel_clk);
    #1;
    bif.ctrl_instruction = {31'd0, relu, total[31:0], len[15:0], 7'd0, bs[8:0]};
    bif.ap_start = 1'b1;
    cur_bs = bs; cur_len = (len == 0) ? 1 : len; cur_total = total; cur_relu = relu; nout = 0;
    @(posedge kernel_clk);
    #1 bif.ap_start = 1'b0;
  endtask
  task automatic drive(int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      int idx;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        bif.s_axis_tvalid = 1'b0;
        @(posedge kernel_clk);
        #1;
      end
      bif.s_axis_tvalid = 1'b1;
      bif.s_axis_tdata = in_beats[i];
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge kernel_clk);
        if (bif.s_axis_tready) begin
          ok = 1;
          idx = (cur_bs + i % cur_len) % 512;
          chk("bias_addr", {503'd0, bif.bias_read_buffer_a_addr}, idx);
          sb.push_back('{ref_beat(in_beats[i], mem[idx], cur_relu), i == cur_total - 1});
        end
        @(posedge kernel_clk);
        #1;
      end
      if (!ok) chk("tready_timeout", 0, 1);
    end
    bif.s_axis_tvalid = 1'b0;
  endtask
  task automatic wait_done(int base, int total);
    for (int t = 0; t < 80 && done_cnt == base; t++) @(negedge kernel_clk);
    repeat (3) @(negedge kernel_clk);
    chk("done_once", done_cnt, base + 1);
    chk("beat_count", nout, total);
    chk("sb_empty", sb.size(), 0);
  endtask
  task automatic fill_100;
    for (int i = 0; i < 16; i++) for (int k = 0; k < 16; k++) in_beats[i][k*32 +: 32] = 32'd100;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    bif.ap_start = 1'b0;
    bif.ctrl_instruction = '0;
    bif.s_axis_tvalid = 1'b0;
    bif.s_axis_tdata = '0;
    for (int w = 0; w < 512; w++) for (int k = 0; k < 16; k++) mem[w][k*32 +: 32] = w + 1;
    fill_100();
    repeat (3) @(posedge kernel_clk);
    @(negedge kernel_clk);
    chk("rst_m_tvalid", bif.m_axis_tvalid, 0);
    chk("rst_m_tlast", bif.m_axis_tlast, 0);
    chk("rst_m_tdata", bif.m_axis_tdata, 0);
    chk("rst_s_tready", bif.s_axis_tready, 0);
    chk("rst_ap_done", bif.ap_done, 0);
    chk("rst_addr", bif.bias_read_buffer_a_addr, 0);
    @(posedge kernel_clk);
    #1 kernel_rst = 1'b0;
    d0 = done_cnt; start(0, 4, 8, 0); drive(8, 0); wait_done(d0, 8);
    chk("t1_lane0_last", last_out[31:0], 32'd104);
    toggle = 1;
    d0 = done_cnt; start(0, 4, 8, 0); drive(8, 1); wait_done(d0, 8);
    toggle = 0;
    d0 = done_cnt; start(510, 3, 6, 0); drive(6, 0); wait_done(d0, 6);
    chk("t3_lane5_last", last_out[191:160], 32'd101);
    for (int k = 0; k < 16; k++) begin
      mem[20][k*32 +: 32] = (k % 2 == 0) ? -32'sd7 : 1000 + k;
      mem[21][k*32 +: 32] = (k % 2 == 0) ? -32'sd7 : 32'd1;
      in_beats[0][k*32 +: 32] = (k % 2 == 0) ? 32'd5 : k;
      in_beats[1][k*32 +: 32] = (k % 2 == 0) ? 32'd5 : 32'h7FFF_FFFF;
    end
    d0 = done_cnt; start(20, 1, 1, 1); drive(1, 0); wait_done(d0, 1);
    chk("relu_lane0", last_out[31:0], 32'd0);
    chk("relu_lane1", last_out[63:32], 32'd1002);
    in_beats[0] = in_beats[1];
    d0 = done_cnt; start(21, 1, 1, 0); drive(1, 0); wait_done(d0, 1);
    chk("wrap_lane0", last_out[31:0], 32'hFFFF_FFFE);
    chk("wrap_lane1", last_out[63:32], 32'h8000_0000);
    fill_100();
    d0 = done_cnt; rc = rdy_cnt;
    start(0, 1, 0, 0);
    @(negedge kernel_clk);
    chk("zero_done_early", bif.ap_done, 0);
    @(negedge kernel_clk);
    chk("zero_done_at_2", bif.ap_done, 1);
    @(negedge kernel_clk);
    chk("zero_done_pulse", bif.ap_done, 0);
    chk("zero_no_tready", rdy_cnt, rc);
    chk("zero_done_once", done_cnt, d0 + 1);
    d0 = done_cnt;
    start(0, 4, 4, 0);
    bif.ctrl_instruction = {31'd0, 1'b1, 32'd2, 16'd1, 7'd0, 9'd100};
    bif.ap_start = 1'b1;
    @(posedge kernel_clk);
    #1 bif.ap_start = 1'b0;
    drive(4, 0); wait_done(d0, 4);
    d0 = done_cnt;
    start(0, 4, 8, 0); drive(3, 0);
    kernel_rst = 1'b1;
    @(posedge kernel_clk);
    #1 kernel_rst = 1'b0;
    @(negedge kernel_clk);
    chk("mid_rst_m_tvalid", bif.m_axis_tvalid, 0);
    chk("mid_rst_m_tlast", bif.m_axis_tlast, 0);
    chk("mid_rst_m_tdata", bif.m_axis_tdata, 0);
    chk("mid_rst_s_tready", bif.s_axis_tready, 0);
    chk("mid_rst_addr", bif.bias_read_buffer_a_addr, 0);
    sb.delete();
    repeat (20) @(negedge kernel_clk);
    chk("mid_rst_no_done", done_cnt, d0);
    d0 = done_cnt; start(0, 4, 8, 0); drive(8, 0); wait_done(d0, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
